// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port program memory (32-bit words, 1-cycle synchronous
// read, byte write mask) between a read-only instruction-fetch port (I) and
// a load/store port (D). Every access takes IDLE -> ISSUE -> WAIT, so the
// peak rate is one access every three cycles. Read data comes back with a
// one-cycle rvalid pulse on the port that asked for it.
//
// Ports
//   CLK, RESET           clock; asynchronous active-low reset
//   i_req/i_address      fetch request, held until i_ready
//   i_ready              fetch accepted this cycle
//   i_rdata/i_rvalid     fetch data, valid while i_rvalid pulses
//   d_req/d_address      load/store request, held until d_ready
//   d_wdata/d_wmask      store data and byte mask (mask 0 = load)
//   d_ready              load/store accepted this cycle
//   d_rdata/d_rvalid     load data, or store-done pulse on d_rvalid
//   mem_address          address to program memory
//   mem_read             read strobe (ISSUE cycle of a read)
//   mem_writeData        write data to program memory
//   mem_writeMask        byte write enables (ISSUE cycle of a write)
//   mem_readData         program memory output, valid the cycle after mem_read
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_ready,
  output logic [31:0]           i_rdata,
  output logic                  i_rvalid,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [31:0]           d_wdata,
  input  logic [3:0]            d_wmask,
  output logic                  d_ready,
  output logic [31:0]           d_rdata,
  output logic                  d_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  output logic [31:0]           mem_writeData,
  output logic [3:0]            mem_writeMask,
  input  logic [31:0]           mem_readData
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state_reg;
  logic                  last_grant_reg;  // 1 = D was granted last
  logic                  port_reg;        // 1 = current access belongs to D
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           wdata_reg;
  logic [3:0]            wmask_reg;
  logic                  mem_read_reg;
  logic [3:0]            mem_wmask_reg;
  logic [31:0]           i_rdata_reg;
  logic                  i_rvalid_reg;
  logic [31:0]           d_rdata_reg;
  logic                  d_rvalid_reg;

  logic grant_i;
  logic grant_d;

  // Tie-break: fixed priority favours I; round-robin favours the port that
  // was not granted last.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_req && d_req) begin
      if ((FIXED_PRIORITY != 0) || last_grant_reg) begin
        grant_i = 1'b1;
      end else begin
        grant_d = 1'b1;
      end
    end else begin
      grant_i = i_req;
      grant_d = d_req;
    end
  end

  // Ready is combinational on the requests; qualifying with RESET keeps it
  // low while reset is held, so every output reads 0 during reset.
  assign i_ready = RESET && (state_reg == IDLE) && grant_i;
  assign d_ready = RESET && (state_reg == IDLE) && grant_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      port_reg       <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wmask_reg      <= '0;
      mem_read_reg   <= 1'b0;
      mem_wmask_reg  <= '0;
      i_rdata_reg    <= '0;
      i_rvalid_reg   <= 1'b0;
      d_rdata_reg    <= '0;
      d_rvalid_reg   <= 1'b0;
    end else begin
      // rvalid is a single-cycle pulse, set only when leaving WAIT
      i_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_ready) begin
            state_reg      <= ISSUE;
            last_grant_reg <= 1'b0;
            port_reg       <= 1'b0;
            addr_reg       <= i_address;
            wdata_reg      <= '0;
            wmask_reg      <= '0;
            mem_read_reg   <= 1'b1;
            mem_wmask_reg  <= '0;
          end else if (d_ready) begin
            state_reg      <= ISSUE;
            last_grant_reg <= 1'b1;
            port_reg       <= 1'b1;
            addr_reg       <= d_address;
            wdata_reg      <= d_wdata;
            wmask_reg      <= d_wmask;
            mem_read_reg   <= (d_wmask == 4'b0000);
            mem_wmask_reg  <= d_wmask;
          end
        end
        ISSUE: begin
          // strobes are live for exactly this one cycle
          state_reg     <= WAIT;
          mem_read_reg  <= 1'b0;
          mem_wmask_reg <= '0;
        end
        WAIT: begin
          state_reg <= IDLE;
          if (!port_reg) begin
            i_rdata_reg  <= mem_readData;
            i_rvalid_reg <= 1'b1;
          end else begin
            d_rvalid_reg <= 1'b1;
            if (wmask_reg == 4'b0000) begin
              d_rdata_reg <= mem_readData;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          mem_read_reg  <= 1'b0;
          mem_wmask_reg <= '0;
        end
      endcase
    end
  end

  assign mem_address   = addr_reg;
  assign mem_writeData = wdata_reg;
  assign mem_read      = mem_read_reg;
  assign mem_writeMask = mem_wmask_reg;
  assign i_rdata       = i_rdata_reg;
  assign i_rvalid      = i_rvalid_reg;
  assign d_rdata       = d_rdata_reg;
  assign d_rvalid      = d_rvalid_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives the arbiter against a behavioural program memory and compares every
// cycle with a transaction-level reference: an access accepted in cycle a
// strobes memory in cycle a+1 and returns data in cycle a+3; the arbiter is
// free again in cycle a+3. A second instance with fixed priority checks the
// I-always-wins rule.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  always #5 CLK = ~CLK;

  logic        i_req = 1'b0;
  logic [31:0] i_address = '0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        d_req = 1'b0;
  logic [31:0] d_address = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wmask = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [31:0] mem_writeData;
  logic [3:0]  mem_writeMask;
  logic [31:0] mem_readData = '0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIORITY(0)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .i_req(i_req), .i_address(i_address), .i_ready(i_ready),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_address(d_address), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_ready(d_ready), .d_rdata(d_rdata),
    .d_rvalid(d_rvalid),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_writeData(mem_writeData), .mem_writeMask(mem_writeMask),
    .mem_readData(mem_readData)
  );

  // fixed-priority instance; only its handshakes are examined
  logic        fp_i_req = 1'b0;
  logic        fp_d_req = 1'b0;
  logic [31:0] fp_addr = 32'h40;
  logic [31:0] fp_zero32 = '0;
  logic [3:0]  fp_zero4 = '0;
  logic        fp_i_ready, fp_i_rvalid, fp_d_ready, fp_d_rvalid;
  logic        fp_mem_read;
  logic [31:0] fp_i_rdata, fp_d_rdata, fp_mem_address, fp_mem_writeData;
  logic [3:0]  fp_mem_writeMask;

  mem_port_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIORITY(1)) u_fp (
    .CLK(CLK), .RESET(RESET),
    .i_req(fp_i_req), .i_address(fp_addr), .i_ready(fp_i_ready),
    .i_rdata(fp_i_rdata), .i_rvalid(fp_i_rvalid),
    .d_req(fp_d_req), .d_address(fp_addr), .d_wdata(fp_zero32),
    .d_wmask(fp_zero4), .d_ready(fp_d_ready), .d_rdata(fp_d_rdata),
    .d_rvalid(fp_d_rvalid),
    .mem_address(fp_mem_address), .mem_read(fp_mem_read),
    .mem_writeData(fp_mem_writeData), .mem_writeMask(fp_mem_writeMask),
    .mem_readData(fp_zero32)
  );

  function automatic logic [31:0] init_word(input int idx);
    return (32'(idx) * 32'h9E3779B1) ^ 32'hC3A50F17;
  endfunction

  // behavioural program memory: 256 words, registered read
  logic [31:0] sim_mem [256];
  bit          sim_mem_ready = 1'b0;
  always @(posedge CLK) begin
    if (!sim_mem_ready) begin
      for (int k = 0; k < 256; k++) sim_mem[k] = init_word(k);
      sim_mem_ready = 1'b1;
    end
    if (mem_read) mem_readData <= sim_mem[mem_address[9:2]];
    for (int b = 0; b < 4; b++) begin
      if (mem_writeMask[b]) sim_mem[mem_address[9:2]][8*b +: 8] = mem_writeData[8*b +: 8];
    end
  end

  // ---------------- reference model state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [256];
  int          cyc = 0;
  bit          have_acc;
  int          acc_cyc;
  bit          acc_is_d;
  logic [31:0] acc_addr, acc_wdata, acc_rdata;
  logic [3:0]  acc_wmask;
  bit          last_d;
  logic [31:0] exp_i_rdata, exp_d_rdata;
  bit          acc_i, acc_d;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic reset_model();
    have_acc    = 1'b0;
    last_d      = 1'b1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
  endtask

  // Called at a falling edge with inputs already driven; checks the cycle,
  // advances the model and returns at the next falling edge.
  task automatic step();
    bit free, win_i, win_d, strobe, done;
    int idx;
    #1;
    free  = !have_acc || (cyc >= acc_cyc + 3);
    win_i = 1'b0;
    win_d = 1'b0;
    if (free) begin
      if (i_req && d_req) begin
        win_i = last_d;
        win_d = !last_d;
      end else begin
        win_i = i_req;
        win_d = d_req;
      end
    end
    strobe = have_acc && (cyc == acc_cyc + 1);
    done   = have_acc && (cyc == acc_cyc + 3);
    if (done && !acc_is_d) exp_i_rdata = acc_rdata;
    if (done && acc_is_d && acc_wmask == 4'b0000) exp_d_rdata = acc_rdata;

    check_val("i_ready", i_ready, win_i);
    check_val("d_ready", d_ready, win_d);
    check_val("one_ready", i_ready & d_ready, 1'b0);
    check_val("mem_read", mem_read, strobe && acc_wmask == 4'b0000);
    check_val("mem_writeMask", mem_writeMask, strobe ? acc_wmask : 4'b0000);
    check_val("i_rvalid", i_rvalid, done && !acc_is_d);
    check_val("d_rvalid", d_rvalid, done && acc_is_d);
    check_val("i_rdata", i_rdata, exp_i_rdata);
    check_val("d_rdata", d_rdata, exp_d_rdata);
    if (have_acc && (cyc == acc_cyc + 1 || cyc == acc_cyc + 2)) begin
      check_val("mem_address", mem_address, acc_addr);
      if (acc_is_d) check_val("mem_writeData", mem_writeData, acc_wdata);
    end

    acc_i = win_i;
    acc_d = win_d;
    if (win_i || win_d) begin
      have_acc  = 1'b1;
      acc_cyc   = cyc;
      acc_is_d  = win_d;
      acc_addr  = win_d ? d_address : i_address;
      acc_wdata = d_wdata;
      acc_wmask = win_d ? d_wmask : 4'b0000;
      last_d    = win_d;
      idx       = int'(acc_addr[9:2]);
      acc_rdata = ref_mem[idx];
      for (int b = 0; b < 4; b++) begin
        if (acc_wmask[b]) ref_mem[idx][8*b +: 8] = acc_wdata[8*b +: 8];
      end
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic issue_i(input logic [31:0] addr);
    bit got;
    got       = 1'b0;
    i_req     = 1'b1;
    i_address = addr;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      got = acc_i;
    end
    i_req = 1'b0;
    if (!got) check_val("issue_i_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue_d(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wm);
    bit got;
    got       = 1'b0;
    d_req     = 1'b1;
    d_address = addr;
    d_wdata   = wd;
    d_wmask   = wm;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      got = acc_d;
    end
    d_req = 1'b0;
    if (!got) check_val("issue_d_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_i_ready"}, i_ready, 1'b0);
    check_val({tag, "_d_ready"}, d_ready, 1'b0);
    check_val({tag, "_i_rvalid"}, i_rvalid, 1'b0);
    check_val({tag, "_d_rvalid"}, d_rvalid, 1'b0);
    check_val({tag, "_i_rdata"}, i_rdata, 32'h0);
    check_val({tag, "_d_rdata"}, d_rdata, 32'h0);
    check_val({tag, "_mem_address"}, mem_address, 32'h0);
    check_val({tag, "_mem_read"}, mem_read, 1'b0);
    check_val({tag, "_mem_writeData"}, mem_writeData, 32'h0);
    check_val({tag, "_mem_writeMask"}, mem_writeMask, 4'h0);
  endtask

  initial begin
    bit expect_d;
    int prev_acc, fp_i_cnt, fp_d_cnt;

    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    reset_model();

    // reset state, with requests up to show ready stays low
    @(negedge CLK);
    i_req = 1'b1;
    d_req = 1'b1;
    #1;
    check_all_zero("reset");
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;

    // single fetch of 0x8
    issue_i(32'h8);
    steps(3);
    check_val("fetch_word2", i_rdata, init_word(2));

    // byte store then read-back
    issue_d(32'h190, 32'h0000AB00, 4'b0010);
    steps(3);
    issue_d(32'h190, 32'h0, 4'b0000);
    steps(3);
    check_val("store_byte1", {24'h0, d_rdata[15:8]}, 32'hAB);

    // both held: grants alternate starting with I
    i_req     = 1'b1;
    i_address = 32'h20;
    d_req     = 1'b1;
    d_address = 32'h24;
    d_wmask   = 4'b0000;
    expect_d  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (acc_i || acc_d) begin
        check_val("alt_grant_is_d", acc_d, expect_d);
        expect_d = !expect_d;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    steps(3);

    // reset during WAIT of a D read: no rvalid, next tie goes to I
    issue_d(32'h30, 32'h0, 4'b0000);
    step();
    #1;
    RESET = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge CLK);
    #1;
    check_all_zero("held_reset");
    @(negedge CLK);
    RESET = 1'b1;
    reset_model();
    step();
    check_val("post_reset_tie_i", acc_i, 1'b1);
    i_req = 1'b0;
    d_req = 1'b0;
    steps(3);

    // back-to-back fetches
    i_req    = 1'b1;
    prev_acc = -1;
    for (int k = 0; k < 12; k++) begin
      i_address = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      step();
      if (acc_i) begin
        if (prev_acc >= 0) check_val("b2b_gap", 32'(cyc - 1 - prev_acc), 32'd3);
        prev_acc = cyc - 1;
      end
    end
    i_req = 1'b0;
    steps(3);

    // randomized traffic; each request held until accepted
    for (int k = 0; k < 400; k++) begin
      if (!i_req || acc_i) begin
        i_req     = ($urandom_range(0, 2) == 0);
        i_address = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!d_req || acc_d) begin
        d_req     = ($urandom_range(0, 2) == 0);
        d_address = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        d_wdata   = $urandom;
        d_wmask   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      end
      step();
    end
    i_req = 1'b0;
    d_req = 1'b0;
    steps(4);

    // fixed priority: 12 cycles of held ties -> 4 I grants, no D grants
    fp_i_cnt = 0;
    fp_d_cnt = 0;
    fp_i_req = 1'b1;
    fp_d_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (fp_i_ready) fp_i_cnt++;
      if (fp_d_ready) fp_d_cnt++;
      @(negedge CLK);
    end
    fp_i_req = 1'b0;
    fp_d_req = 1'b0;
    check_val("fp_i_grants", 32'(fp_i_cnt), 32'd4);
    check_val("fp_d_grants", 32'(fp_d_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
